// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pkg : shared widths and writeback record for the RV32 core      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wr_arbiter_if : writeback requests, regfile write, bypass    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface regfile_wr_arbiter_if;
  import rv32_pkg::*;

  logic            flush;
  logic            req0_valid;
  logic [AW-1:0]   req0_addr;
  logic [XLEN-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [AW-1:0]   req1_addr;
  logic [XLEN-1:0] req1_data;
  logic            req1_ready;
  logic            rf_wr_en;
  logic [AW-1:0]   rf_wr_addr;
  logic [XLEN-1:0] rf_din;
  logic [AW-1:0]   rd_addr1;
  logic [AW-1:0]   rd_addr2;
  logic            fwd_hit1;
  logic            fwd_hit2;
  logic [XLEN-1:0] fwd_data;
  logic            starve_o;

  modport master (
    output flush,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rf_wr_en, rf_wr_addr, rf_din,
    output rd_addr1, rd_addr2,
    input  fwd_hit1, fwd_hit2, fwd_data,
    input  starve_o
  );

  modport slave (
    input  flush,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rf_wr_en, rf_wr_addr, rf_din,
    input  rd_addr1, rd_addr2,
    output fwd_hit1, fwd_hit2, fwd_data,
    output starve_o
  );

endinterface
`default_nettype wire

// File: rtl/rr_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_wait_counter : saturating stall counter for the low-priority port |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_wait_counter #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 3
) (
  input  logic clk,
  input  logic arst,
  input  logic flush,
  input  logic req_valid,
  input  logic gnt,
  output logic force_req
);

  localparam logic [CW-1:0] C_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] r_wcnt;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_wcnt <= '0;
    end else if (flush || gnt || !req_valid) begin
      r_wcnt <= '0;
    end else if (r_wcnt != C_MAX) begin
      r_wcnt <= r_wcnt + CW'(1);
    end
  end

  assign force_req = req_valid & (r_wcnt == C_MAX);

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wr_arbiter : two-source arbiter for the regfile write port   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_wr_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 3
) (
  input  logic                 clk,
  input  logic                 arst,
  regfile_wr_arbiter_if.slave  bus
);
  import rv32_pkg::*;

  wb_req_t w_req0;
  wb_req_t w_req1;
  wb_req_t w_sel;
  wb_req_t r_wr;
  logic    w_force;
  logic    w_open;
  logic    w_gnt0;
  logic    w_gnt1;

  assign w_req0 = '{valid: bus.req0_valid, addr: bus.req0_addr, data: bus.req0_data};
  assign w_req1 = '{valid: bus.req1_valid, addr: bus.req1_addr, data: bus.req1_data};

  rr_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (CW)
  ) u_wait_cnt (
    .clk       (clk),
    .arst      (arst),
    .flush     (bus.flush),
    .req_valid (bus.req1_valid),
    .gnt       (w_gnt1),
    .force_req (w_force)
  );

  // No acceptance while flushing or while reset is asserted.
  assign w_open = arst & ~bus.flush;
  assign w_gnt1 = w_open & w_req1.valid & (~w_req0.valid | w_force);
  assign w_gnt0 = w_open & w_req0.valid & ~w_gnt1;
  assign w_sel  = w_gnt1 ? w_req1 : w_req0;

  assign bus.req0_ready = w_open & ~w_force;
  assign bus.req1_ready = w_gnt1;
  assign bus.starve_o   = w_force;

  // x0 grants are consumed but never raise the write enable.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_wr <= '0;
    end else if (w_gnt0 || w_gnt1) begin
      r_wr.valid <= (w_sel.addr != REG_X0);
      r_wr.addr  <= w_sel.addr;
      r_wr.data  <= w_sel.data;
    end else begin
      r_wr.valid <= 1'b0;
    end
  end

  assign bus.rf_wr_en   = r_wr.valid;
  assign bus.rf_wr_addr = r_wr.addr;
  assign bus.rf_din     = r_wr.data;

  assign bus.fwd_hit1 = r_wr.valid & (r_wr.addr == bus.rd_addr1) & (bus.rd_addr1 != REG_X0);
  assign bus.fwd_hit2 = r_wr.valid & (r_wr.addr == bus.rd_addr2) & (bus.rd_addr2 != REG_X0);
  assign bus.fwd_data = r_wr.data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_wr_arbiter : directed bench with a cycle-level model      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_regfile_wr_arbiter;

  localparam int MAX_WAIT = 4;

  logic clk;
  logic arst;
  int   n_chk;
  int   n_fail;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (3)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Regfile sitting one level up: commits whatever the write stage presents.
  logic [31:0] mem [32];
  always @(posedge clk) if (bus.rf_wr_en === 1'b1) mem[bus.rf_wr_addr] <= bus.rf_din;

  // Model state: staged write record and how many cycles req1 has stalled in a row.
  logic        m_en,  n_en;
  logic [4:0]  m_addr, n_addr;
  logic [31:0] m_din, n_din;
  int          m_wait, n_wait;

  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      m_en <= 1'b0; m_addr <= '0; m_din <= '0; m_wait <= 0;
    end else begin
      m_en <= n_en; m_addr <= n_addr; m_din <= n_din; m_wait <= n_wait;
    end
  end

  always @(negedge clk) begin
    logic e_force, e_g0, e_g1, e_r0, e_open;
    e_open  = arst && !bus.flush;
    e_force = arst && bus.req1_valid && (m_wait >= MAX_WAIT);
    e_g1    = e_open && bus.req1_valid && (!bus.req0_valid || e_force);
    e_g0    = e_open && bus.req0_valid && !e_g1;
    e_r0    = e_open && !e_force;
    chk("m_req0_ready", bus.req0_ready, e_r0);
    chk("m_req1_ready", bus.req1_ready, e_g1);
    chk("m_starve",     bus.starve_o,   e_force);
    chk("m_wr_en",      bus.rf_wr_en,   m_en);
    chk("m_wr_addr",    bus.rf_wr_addr, m_addr);
    chk("m_din",        bus.rf_din,     m_din);
    chk("m_hit1",       bus.fwd_hit1,   m_en && m_addr == bus.rd_addr1 && bus.rd_addr1 != 0);
    chk("m_hit2",       bus.fwd_hit2,   m_en && m_addr == bus.rd_addr2 && bus.rd_addr2 != 0);
    chk("m_fwd_data",   bus.fwd_data,   m_din);
    if (e_g1 || e_g0) begin
      n_addr = e_g1 ? bus.req1_addr : bus.req0_addr;
      n_din  = e_g1 ? bus.req1_data : bus.req0_data;
      n_en   = (n_addr != 0);
    end else begin
      n_en = 1'b0; n_addr = m_addr; n_din = m_din;
    end
    if (!bus.req1_valid || e_g1 || bus.flush) n_wait = 0;
    else n_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
  endtask

  task automatic set1(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    logic got;
    n_chk = 0; n_fail = 0;
    bus.flush = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    set0(1'b0, 5'd0, 32'h0);
    set1(1'b0, 5'd0, 32'h0);
    arst = 1'b1;
    #1 arst = 1'b0;

    // Reset held while req0 asks to write x5.
    set0(1'b1, 5'd5, 32'hDEAD);
    step(); step();
    #2;
    chk("t1_rst_en",    bus.rf_wr_en,   0);
    chk("t1_rst_din",   bus.rf_din,     0);
    chk("t1_rst_ready", bus.req0_ready, 0);
    arst = 1'b1;
    step();
    set0(1'b0, 5'd0, 32'h0);
    #2;
    chk("t1_first_en",   bus.rf_wr_en,   1);
    chk("t1_first_addr", bus.rf_wr_addr, 5);
    chk("t1_first_din",  bus.rf_din,     32'hDEAD);
    step();

    // Contention: req1 stalls four cycles, then is forced.
    for (int c = 1; c <= 6; c++) begin
      set0(1'b1, c[4:0], 32'h100 + c);
      set1(c <= 5, 5'd7, 32'h1234);
      #2;
      if (c <= 4) chk("t2_r1_wait", bus.req1_ready, 0);
      if (c == 5) begin
        chk("t2_starve",  bus.starve_o,   1);
        chk("t2_r1_gnt",  bus.req1_ready, 1);
        chk("t2_r0_hold", bus.req0_ready, 0);
      end
      if (c == 6) begin
        chk("t2_wr_addr", bus.rf_wr_addr, 7);
        chk("t2_wr_din",  bus.rf_din,     32'h1234);
        chk("t2_starve0", bus.starve_o,   0);
      end
      step();
    end

    // x0 write is accepted but never enabled.
    set0(1'b1, 5'd0, 32'hFFFFFFFF);
    set1(1'b0, 5'd0, 32'h0);
    #2;
    chk("t3_ready", bus.req0_ready, 1);
    step();
    set0(1'b1, 5'd3, 32'hA5A5);
    #2;
    chk("t3_en",   bus.rf_wr_en, 0);
    chk("t3_hit1", bus.fwd_hit1, 0);
    step();

    // Bypass window.
    set0(1'b0, 5'd0, 32'h0);
    bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd4;
    #2;
    chk("t4_hit1", bus.fwd_hit1, 1);
    chk("t4_hit2", bus.fwd_hit2, 0);
    chk("t4_data", bus.fwd_data, 32'hA5A5);
    step();
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;

    // Flush: staged x8 still commits, x9 is refused, wait count restarts.
    set0(1'b1, 5'd8, 32'h88);
    set1(1'b1, 5'd9, 32'h99);
    #2;
    chk("t4_mem3", mem[3], 32'hA5A5);
    step();
    set0(1'b1, 5'd9, 32'h99);
    bus.flush = 1'b1;
    #2;
    chk("t5_r0_ready", bus.req0_ready, 0);
    chk("t5_r1_ready", bus.req1_ready, 0);
    chk("t5_en_live",  bus.rf_wr_en,   1);
    chk("t5_addr8",    bus.rf_wr_addr, 8);
    step();
    bus.flush = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      set0(1'b1, 5'd10 + c[4:0], 32'h200 + c);
      #2;
      if (c == 1) begin
        chk("t5_en_off", bus.rf_wr_en, 0);
        chk("t5_mem8",   mem[8],       32'h88);
      end
      chk("t5_starve", bus.starve_o, c == 5);
      step();
    end

    // Async reset pulse while req1 has stalled three cycles.
    set1(1'b0, 5'd0, 32'h0);
    step();
    set1(1'b1, 5'd12, 32'hC0DE);
    for (int c = 1; c <= 3; c++) begin
      set0(1'b1, 5'd20 + c[4:0], 32'h300 + c);
      step();
    end
    set0(1'b1, 5'd24, 32'h304);
    #1 arst = 1'b0;
    #1;
    chk("t6_en_drop",  bus.rf_wr_en,   0);
    chk("t6_ready_rst", bus.req1_ready, 0);
    arst = 1'b1;
    #1;
    stalls = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (k > 0) begin step(); #2; end
      if (bus.req1_ready) got = 1'b1;
      else stalls++;
    end
    chk("t6_granted", got,    1);
    chk("t6_stalls",  stalls, MAX_WAIT);
    step();
    set0(1'b0, 5'd0, 32'h0);
    set1(1'b0, 5'd0, 32'h0);
    #2;
    chk("t6_wr_addr", bus.rf_wr_addr, 12);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
